// File: rtl/snake_obj_source.sv
`default_nettype none
// snake_obj_source: snake game state plus 1-cycle-latency object flags for the tile scanner.
// Optional macro SNAKE_WRAP_EN: toroidal grid, no border tiles, only self-collision kills.
module snake_obj_source #(
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 12,
  parameter int MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic       head,
  output logic       body,
  output logic       apple,
  output logic       border,
  input  logic       step,
  input  logic [1:0] dir,
  input  logic       apple_load,
  input  logic [3:0] apple_x,
  input  logic [3:0] apple_y,
  output logic       ate,
  output logic       dead,
  output logic       win,
  output logic [4:0] length
);

`ifdef SNAKE_WRAP_EN
  localparam bit c_WRAP = 1'b1;
`else
  localparam bit c_WRAP = 1'b0;
`endif
  localparam logic [3:0] c_XMAX    = 4'(GRID_W - 1);
  localparam logic [3:0] c_YMAX    = 4'(GRID_H - 1);
  localparam logic [4:0] c_GRID_W  = 5'(GRID_W);
  localparam logic [4:0] c_GRID_H  = 5'(GRID_H);
  localparam logic [4:0] c_MAX_LEN = 5'(MAX_LEN);

  typedef enum logic [1:0] {
    ST_ALIVE = 2'd0,
    ST_DEAD  = 2'd1,
    ST_WIN   = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_hdg;
  logic [3:0] r_seg_x [MAX_LEN];
  logic [3:0] r_seg_y [MAX_LEN];
  logic [3:0] r_apple_x;
  logic [3:0] r_apple_y;

  function automatic logic f_on_border(input logic [3:0] fx, input logic [3:0] fy);
    return (fx == 4'd0) || (fx == c_XMAX) || (fy == 4'd0) || (fy == c_YMAX);
  endfunction

  function automatic logic f_in_range(input logic [3:0] fx, input logic [3:0] fy);
    return ({1'b0, fx} < c_GRID_W) && ({1'b0, fy} < c_GRID_H);
  endfunction

  // Query decode against the current (pre-step) state.
  logic w_q_in, w_q_border, w_q_head, w_q_body, w_q_apple;
  always_comb begin
    w_q_in     = f_in_range(x, y);
    w_q_border = !c_WRAP && f_on_border(x, y);
    w_q_head   = (x == r_seg_x[0]) && (y == r_seg_y[0]);
    w_q_apple  = (x == r_apple_x) && (y == r_apple_y);
    w_q_body   = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((5'(i) < length) && (x == r_seg_x[i]) && (y == r_seg_y[i])) begin
        w_q_body = 1'b1;
      end
    end
  end

  logic [1:0] w_hdg;
  logic [3:0] w_nh_x, w_nh_y;
  logic       w_grow, w_hit_body, w_hit, w_load_ok;
  always_comb begin
    w_hdg  = (dir == (r_hdg ^ 2'b10)) ? r_hdg : dir;
    w_nh_x = r_seg_x[0];
    w_nh_y = r_seg_y[0];
    case (w_hdg)
      2'b00:   w_nh_x = (c_WRAP && r_seg_x[0] == c_XMAX) ? 4'd0   : r_seg_x[0] + 4'd1;
      2'b01:   w_nh_y = (c_WRAP && r_seg_y[0] == c_YMAX) ? 4'd0   : r_seg_y[0] + 4'd1;
      2'b10:   w_nh_x = (c_WRAP && r_seg_x[0] == 4'd0)   ? c_XMAX : r_seg_x[0] - 4'd1;
      default: w_nh_y = (c_WRAP && r_seg_y[0] == 4'd0)   ? c_YMAX : r_seg_y[0] - 4'd1;
    endcase
    w_grow     = (w_nh_x == r_apple_x) && (w_nh_y == r_apple_y);
    // The tail vacates its cell on a plain move, so it only blocks when growing.
    w_hit_body = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (((5'(i) < length - 5'd1) || ((5'(i) == length - 5'd1) && w_grow)) &&
          (w_nh_x == r_seg_x[i]) && (w_nh_y == r_seg_y[i])) begin
        w_hit_body = 1'b1;
      end
    end
    w_hit     = w_hit_body || (!c_WRAP && f_on_border(w_nh_x, w_nh_y));
    w_load_ok = f_in_range(apple_x, apple_y) && (c_WRAP || !f_on_border(apple_x, apple_y));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ALIVE;
      r_hdg   <= 2'b10;
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= 4'd0;
        r_seg_y[i] <= 4'd0;
      end
      r_seg_x[0] <= 4'd4; r_seg_y[0] <= 4'd4;
      r_seg_x[1] <= 4'd5; r_seg_y[1] <= 4'd4;
      r_seg_x[2] <= 4'd6; r_seg_y[2] <= 4'd4;
      r_apple_x <= 4'd10;
      r_apple_y <= 4'd6;
      length    <= 5'd3;
      head      <= 1'b0;
      body      <= 1'b0;
      apple     <= 1'b0;
      border    <= 1'b0;
      ate       <= 1'b0;
      dead      <= 1'b0;
      win       <= 1'b0;
    end else begin
      border <= w_q_in && w_q_border;
      head   <= w_q_in && !w_q_border && w_q_head;
      body   <= w_q_in && !w_q_border && !w_q_head && w_q_body;
      apple  <= w_q_in && !w_q_border && !w_q_head && !w_q_body && w_q_apple;
      ate    <= 1'b0;
      if (apple_load && w_load_ok) begin
        r_apple_x <= apple_x;
        r_apple_y <= apple_y;
      end
      if (step && (r_state == ST_ALIVE)) begin
        r_hdg <= w_hdg;
        if (w_hit) begin
          r_state <= ST_DEAD;
          dead    <= 1'b1;
        end else begin
          for (int i = MAX_LEN - 1; i > 0; i--) begin
            r_seg_x[i] <= r_seg_x[i-1];
            r_seg_y[i] <= r_seg_y[i-1];
          end
          r_seg_x[0] <= w_nh_x;
          r_seg_y[0] <= w_nh_y;
          if (w_grow) begin
            length <= length + 5'd1;
            ate    <= 1'b1;
            if (length + 5'd1 == c_MAX_LEN) begin
              r_state <= ST_WIN;
              win     <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snake_obj_source.sv
`default_nettype none
// tb_snake_obj_source: directed self-checking bench for snake_obj_source.
module tb_snake_obj_source;

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] x, y;
  logic       head, body, apple, border;
  logic       step;
  logic [1:0] dir;
  logic       apple_load;
  logic [3:0] apple_x, apple_y;
  logic       ate, dead, win;
  logic [4:0] length;

  int n_run;
  int n_fail;

  snake_obj_source dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .y          (y),
    .head       (head),
    .body       (body),
    .apple      (apple),
    .border     (border),
    .step       (step),
    .dir        (dir),
    .apple_load (apple_load),
    .apple_x    (apple_x),
    .apple_y    (apple_y),
    .ate        (ate),
    .dead       (dead),
    .win        (win),
    .length     (length)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- stimulus helpers (no checking) ----
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; step = 1'b0; apple_load = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_step(input logic [1:0] d);
    @(negedge clk);
    step = 1'b1; dir = d;
    @(posedge clk); #1;
    step = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] ax, input logic [3:0] ay);
    @(negedge clk);
    apple_load = 1'b1; apple_x = ax; apple_y = ay;
    @(posedge clk); #1;
    apple_load = 1'b0;
  endtask

  task automatic do_step_load(input logic [1:0] d, input logic [3:0] ax, input logic [3:0] ay);
    @(negedge clk);
    step = 1'b1; dir = d; apple_load = 1'b1; apple_x = ax; apple_y = ay;
    @(posedge clk); #1;
    step = 1'b0; apple_load = 1'b0;
  endtask

  // Flags returned as {border, head, body, apple}.
  task automatic do_query(input logic [3:0] qx, input logic [3:0] qy, output logic [3:0] f);
    @(negedge clk);
    x = qx; y = qy;
    @(posedge clk); #1;
    f = {border, head, body, apple};
  endtask

  // ---- tests ----
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; x = 4'd4; y = 4'd4;
    @(posedge clk); #1;
    n_run++; if ({border, head, body, apple} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {border, head, body, apple}); end
    @(posedge clk); #1;
    n_run++; if (length !== 5'd3) begin n_fail++; $display("FAIL reset_len: got %0d want 3", length); end
    n_run++; if ({ate, dead, win} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got ate/dead/win=%b want 000", {ate, dead, win}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_query();
    logic [11:0] vec [8];
    logic [3:0]  f;
    vec[0] = {4'd4,  4'd4,  4'b0100};
    vec[1] = {4'd5,  4'd4,  4'b0010};
    vec[2] = {4'd6,  4'd4,  4'b0010};
    vec[3] = {4'd10, 4'd6,  4'b0001};
    vec[4] = {4'd0,  4'd3,  (WRAP ? 4'b0000 : 4'b1000)};
    vec[5] = {4'd7,  4'd7,  4'b0000};
    vec[6] = {4'd5,  4'd12, 4'b0000};
    vec[7] = {4'd15, 4'd11, (WRAP ? 4'b0000 : 4'b1000)};
    for (int i = 0; i < 8; i++) begin
      do_query(vec[i][11:8], vec[i][7:4], f);
      n_run++; if (f !== vec[i][3:0]) begin n_fail++; $display("FAIL query(%0d,%0d): got %b want %b", vec[i][11:8], vec[i][7:4], f, vec[i][3:0]); end
    end
    n_run++; if (length !== 5'd3 || dead !== 1'b0) begin n_fail++; $display("FAIL query_state: got len=%0d dead=%b want 3/0", length, dead); end
  endtask

  task automatic test_reverse();
    logic [3:0] f;
    do_reset();
    do_step(2'b00);
    do_query(4'd3, 4'd4, f);
    n_run++; if (f !== 4'b0100) begin n_fail++; $display("FAIL rev_head: got %b want 0100", f); end
    do_query(4'd5, 4'd4, f);
    n_run++; if (f !== 4'b0010) begin n_fail++; $display("FAIL rev_body: got %b want 0010", f); end
    do_query(4'd6, 4'd4, f);
    n_run++; if (f !== 4'b0000) begin n_fail++; $display("FAIL rev_oldtail: got %b want 0000", f); end
  endtask

  task automatic test_eat();
    logic [3:0] f;
    do_load(4'd2, 4'd4);
    do_query(4'd2, 4'd4, f);
    n_run++; if (f !== 4'b0001) begin n_fail++; $display("FAIL eat_apple_loaded: got %b want 0001", f); end
    do_step(2'b10);
    n_run++; if (ate !== 1'b1) begin n_fail++; $display("FAIL eat_pulse: got %b want 1", ate); end
    @(posedge clk); #1;
    n_run++; if (ate !== 1'b0) begin n_fail++; $display("FAIL eat_pulse_end: got %b want 0", ate); end
    n_run++; if (length !== 5'd4) begin n_fail++; $display("FAIL eat_len: got %0d want 4", length); end
    do_query(4'd2, 4'd4, f);
    n_run++; if (f !== 4'b0100) begin n_fail++; $display("FAIL eat_head: got %b want 0100", f); end
    do_query(4'd5, 4'd4, f);
    n_run++; if (f !== 4'b0010) begin n_fail++; $display("FAIL eat_tail: got %b want 0010", f); end
    do_load(4'd8, 4'd8);
    do_query(4'd8, 4'd8, f);
    n_run++; if (f !== 4'b0001) begin n_fail++; $display("FAIL reload_apple: got %b want 0001", f); end
    do_load(4'd0, 4'd5);
    do_query(4'd0, 4'd5, f);
    n_run++; if (f !== (WRAP ? 4'b0001 : 4'b1000)) begin n_fail++; $display("FAIL edge_load_q: got %b want %b", f, (WRAP ? 4'b0001 : 4'b1000)); end
    do_query(4'd8, 4'd8, f);
    n_run++; if (f !== (WRAP ? 4'b0000 : 4'b0001)) begin n_fail++; $display("FAIL edge_load_old: got %b want %b", f, (WRAP ? 4'b0000 : 4'b0001)); end
  endtask

  task automatic test_wall();
    logic [3:0] f;
    do_reset();
    do_step(2'b10);
    do_step(2'b10);
    do_step(2'b10);
    n_run++; if (dead !== 1'b0) begin n_fail++; $display("FAIL wall_pre: got dead=%b want 0", dead); end
`ifdef SNAKE_WRAP_EN
    do_step(2'b10);
    do_step(2'b10);
    n_run++; if (dead !== 1'b0) begin n_fail++; $display("FAIL wrap_dead: got %b want 0", dead); end
    do_query(4'd15, 4'd4, f);
    n_run++; if (f !== 4'b0100) begin n_fail++; $display("FAIL wrap_head: got %b want 0100", f); end
    do_query(4'd0, 4'd4, f);
    n_run++; if (f !== 4'b0010) begin n_fail++; $display("FAIL wrap_body: got %b want 0010", f); end
    do_query(4'd0, 4'd3, f);
    n_run++; if (f !== 4'b0000) begin n_fail++; $display("FAIL wrap_noborder: got %b want 0000", f); end
`else
    do_step(2'b10);
    n_run++; if (dead !== 1'b1) begin n_fail++; $display("FAIL wall_dead: got %b want 1", dead); end
    do_step(2'b01);
    do_query(4'd1, 4'd4, f);
    n_run++; if (f !== 4'b0100) begin n_fail++; $display("FAIL wall_frozen_head: got %b want 0100", f); end
    do_query(4'd3, 4'd4, f);
    n_run++; if (f !== 4'b0010) begin n_fail++; $display("FAIL wall_frozen_tail: got %b want 0010", f); end
    do_query(4'd0, 4'd4, f);
    n_run++; if (f !== 4'b1000) begin n_fail++; $display("FAIL wall_border: got %b want 1000", f); end
    n_run++; if (dead !== 1'b1 || length !== 5'd3) begin n_fail++; $display("FAIL wall_hold: got dead=%b len=%0d want 1/3", dead, length); end
`endif
  endtask

  task automatic test_tail_chase();
    logic [3:0] f;
    do_reset();
    do_load(4'd3, 4'd4);
    do_step(2'b10);
    do_step(2'b01);
    do_step(2'b00);
    do_step(2'b11);
    n_run++; if (dead !== 1'b0 || length !== 5'd4) begin n_fail++; $display("FAIL chase_alive: got dead=%b len=%0d want 0/4", dead, length); end
    do_query(4'd4, 4'd4, f);
    n_run++; if (f !== 4'b0100) begin n_fail++; $display("FAIL chase_head: got %b want 0100", f); end
    do_query(4'd3, 4'd4, f);
    n_run++; if (f !== 4'b0010) begin n_fail++; $display("FAIL chase_tail: got %b want 0010", f); end
    do_query(4'd5, 4'd4, f);
    n_run++; if (f !== 4'b0000) begin n_fail++; $display("FAIL chase_vacated: got %b want 0000", f); end
  endtask

  task automatic test_self_collision();
    logic [3:0] f;
    do_reset();
    do_load(4'd3, 4'd4);
    do_step(2'b10);
    do_load(4'd2, 4'd4);
    do_step(2'b10);
    do_step(2'b01);
    do_step(2'b00);
    n_run++; if (dead !== 1'b0) begin n_fail++; $display("FAIL self_pre: got dead=%b want 0", dead); end
    do_step(2'b11);
    n_run++; if (dead !== 1'b1 || length !== 5'd5) begin n_fail++; $display("FAIL self_dead: got dead=%b len=%0d want 1/5", dead, length); end
    do_query(4'd3, 4'd5, f);
    n_run++; if (f !== 4'b0100) begin n_fail++; $display("FAIL self_frozen: got %b want 0100", f); end
    @(negedge clk);
    rst = 1'b1; step = 1'b1; dir = 2'b10;
    @(posedge clk); #1;
    n_run++; if (dead !== 1'b0 || length !== 5'd3) begin n_fail++; $display("FAIL rst_mid_step: got dead=%b len=%0d want 0/3", dead, length); end
    @(negedge clk);
    rst = 1'b0; step = 1'b0;
    do_query(4'd4, 4'd4, f);
    n_run++; if (f !== 4'b0100) begin n_fail++; $display("FAIL rst_mid_head: got %b want 0100", f); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] f;
    do_reset();
    do_load(4'd3, 4'd4);
    do_step_load(2'b10, 4'd7, 4'd7);
    n_run++; if (ate !== 1'b1 || length !== 5'd4) begin n_fail++; $display("FAIL sim_eat: got ate=%b len=%0d want 1/4", ate, length); end
    do_query(4'd7, 4'd7, f);
    n_run++; if (f !== 4'b0001) begin n_fail++; $display("FAIL sim_newapple: got %b want 0001", f); end
    do_step_load(2'b10, 4'd2, 4'd4);
    n_run++; if (ate !== 1'b0 || length !== 5'd4) begin n_fail++; $display("FAIL sim_oldapple: got ate=%b len=%0d want 0/4", ate, length); end
    do_query(4'd2, 4'd4, f);
    n_run++; if (f !== 4'b0100) begin n_fail++; $display("FAIL sim_head_over_apple: got %b want 0100", f); end
    do_query(4'd7, 4'd7, f);
    n_run++; if (f !== 4'b0000) begin n_fail++; $display("FAIL sim_apple_moved: got %b want 0000", f); end
  endtask

  task automatic test_win();
    logic [9:0] path [13];
    logic [3:0] f;
    path[0]  = {2'b10, 4'd3, 4'd4};
    path[1]  = {2'b10, 4'd2, 4'd4};
    path[2]  = {2'b10, 4'd1, 4'd4};
    for (int i = 0; i < 6; i++) path[3+i] = {2'b01, 4'd1, 4'(5 + i)};
    path[9]  = {2'b00, 4'd2, 4'd10};
    path[10] = {2'b00, 4'd3, 4'd10};
    path[11] = {2'b00, 4'd4, 4'd10};
    path[12] = {2'b00, 4'd5, 4'd10};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      do_load(path[i][7:4], path[i][3:0]);
      do_step(path[i][9:8]);
    end
    n_run++; if (length !== 5'd15 || win !== 1'b0 || ate !== 1'b1) begin n_fail++; $display("FAIL win_pre: got len=%0d win=%b ate=%b want 15/0/1", length, win, ate); end
    do_load(path[12][7:4], path[12][3:0]);
    do_step(path[12][9:8]);
    n_run++; if (ate !== 1'b1 || win !== 1'b1 || dead !== 1'b0) begin n_fail++; $display("FAIL win_final: got ate=%b win=%b dead=%b want 1/1/0", ate, win, dead); end
    n_run++; if (length !== 5'd16) begin n_fail++; $display("FAIL win_len: got %0d want 16", length); end
    do_step(2'b00);
    do_query(4'd5, 4'd10, f);
    n_run++; if (f !== 4'b0100) begin n_fail++; $display("FAIL win_frozen: got %b want 0100", f); end
    do_query(4'd6, 4'd10, f);
    n_run++; if (f !== 4'b0000 || win !== 1'b1) begin n_fail++; $display("FAIL win_hold: got %b win=%b want 0000/1", f, win); end
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    rst = 1'b1; step = 1'b0; dir = 2'b10; apple_load = 1'b0;
    apple_x = 4'd0; apple_y = 4'd0; x = 4'd0; y = 4'd0;
    test_reset();
    test_query();
    test_reverse();
    test_eat();
    test_wall();
    test_tail_chase();
    test_self_collision();
    test_back_to_back();
    test_win();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
